// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file read, writeback bypass, per-register
// scoreboard hazard blocking, registered execute handoff and stall counter.
module operand_fetch #(
  parameter int NREGS      = 32,
  parameter int XLEN       = 32,
  parameter int LOG2_NREGS = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LOG2_NREGS-1:0] in_rs1,
  input  logic [LOG2_NREGS-1:0] in_rs2,
  input  logic [LOG2_NREGS-1:0] in_rd,
  input  logic                  in_rd_we,

  output logic [LOG2_NREGS-1:0] rf_read_addr1,
  output logic [LOG2_NREGS-1:0] rf_read_addr2,
  input  logic [XLEN-1:0]       rf_read_data1,
  input  logic [XLEN-1:0]       rf_read_data2,

  input  logic                  wb_valid,
  input  logic [LOG2_NREGS-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,

  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_op1,
  output logic [XLEN-1:0]       out_op2,
  output logic [LOG2_NREGS-1:0] out_rd,
  output logic                  out_rd_we,

  output logic [15:0]           stall_count
);

  logic [NREGS-1:0]      r_pending;
  logic                  r_out_valid;
  logic [XLEN-1:0]       r_out_op1;
  logic [XLEN-1:0]       r_out_op2;
  logic [LOG2_NREGS-1:0] r_out_rd;
  logic                  r_out_rd_we;
  logic [15:0]           r_stall_count;

  logic [NREGS-1:0]      w_clr;
  logic [NREGS-1:0]      w_set;
  logic [NREGS-1:0]      w_busy;
  logic [NREGS-1:0]      w_pending_nxt;
  logic                  w_hazard;
  logic                  w_out_free;
  logic                  w_accept;
  logic [XLEN-1:0]       w_op1;
  logic [XLEN-1:0]       w_op2;

  assign rf_read_addr1 = in_rs1;
  assign rf_read_addr2 = in_rs2;

  // A register being written back this cycle is no longer busy.
  always_comb begin
    w_clr = '0;
    if (wb_valid && (wb_addr != '0)) w_clr[wb_addr] = 1'b1;
  end

  assign w_busy = r_pending & ~w_clr;

  assign w_hazard = in_valid && (w_busy[in_rs1] || w_busy[in_rs2] ||
                                 (in_rd_we && w_busy[in_rd]));

  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = !w_hazard && w_out_free;
  assign w_accept   = in_valid && in_ready;

  always_comb begin
    w_set = '0;
    if (w_accept && in_rd_we && (in_rd != '0)) w_set[in_rd] = 1'b1;
  end

  // Set applied after clear so a new producer of the same register stays tracked.
  always_comb begin
    w_pending_nxt    = (r_pending & ~w_clr) | w_set;
    w_pending_nxt[0] = 1'b0;
  end

  // The register file returns the pre-write value this cycle, so bypass wb_data.
  always_comb begin
    if (in_rs1 == '0)       w_op1 = '0;
    else if (w_clr[in_rs1]) w_op1 = wb_data;
    else                    w_op1 = rf_read_data1;

    if (in_rs2 == '0)       w_op2 = '0;
    else if (w_clr[in_rs2]) w_op2 = wb_data;
    else                    w_op2 = rf_read_data2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_op1   <= '0;
      r_out_op2   <= '0;
      r_out_rd    <= '0;
      r_out_rd_we <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_op1   <= w_op1;
      r_out_op2   <= w_op2;
      r_out_rd    <= in_rd;
      r_out_rd_we <= in_rd_we;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Only scoreboard stalls are counted; downstream backpressure is not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (w_hazard && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_op1     = r_out_op1;
  assign out_op2     = r_out_op2;
  assign out_rd      = r_out_rd;
  assign out_rd_we   = r_out_rd_we;
  assign stall_count = r_stall_count;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage that reads the integer register file on behalf of the issue pipeline. It drives the register file's two read addresses and bypasses same-cycle writeback data. A per-register scoreboard blocks instructions whose sources or destination have a write still in flight. Results go to a registered valid/ready output toward execute, and a saturating counter records hazard stall cycles.

## Interface
- nregs, 32, number of architectural registers; register 0 reads as zero and is never tracked.
- xlen, 32, register width in bits.
- log2_nregs, $clog2(nregs), register address width.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
- in_rs1, in_rs2  in  log2_nregs  source register addresses.
- in_rd  in  log2_nregs  destination register address.
- in_rd_we  in  1  instruction writes in_rd.
- rf_read_addr1, rf_read_addr2  out  log2_nregs  register file read addresses; combinational copies of in_rs1/in_rs2.
- rf_read_data1, rf_read_data2  in  xlen  combinational register file read data.
- wb_valid  in  1  writeback occurring this cycle; the same bus writes the register file at this clock edge.
- wb_addr  in  log2_nregs  writeback register.
- wb_data  in  xlen  writeback value.
- out_valid  out  1  registered operand bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_op1, out_op2  out  xlen  resolved operands.
- out_rd  out  log2_nregs  registered destination.
- out_rd_we  out  1  registered write flag.
- stall_count  out  16  saturating count of hazard stall cycles.

## Operation
- Scoreboard: nregs pending bits, bit 0 hard-wired 0.
- clr(r) = wb_valid && wb_addr==r && r!=0. A write to a non-pending register, or to r0, has no scoreboard effect.
- Busy(r) = pending[r] && !clr(r).
- Hazard = in_valid && (Busy(in_rs1) || Busy(in_rs2) || (in_rd_we && Busy(in_rd))). A WAW conflict stalls.
- in_ready = !hazard && (!out_valid || out_ready). in_ready is combinational on the in_* fields and the wb_* bus.
- On accept with in_rd_we && in_rd!=0: set pending[in_rd]. If the same register is also cleared that cycle, set wins and the new producer is tracked.
- Clear: pending[wb_addr] <= 0 on clr, unless a set to that register happens in the same cycle.
- Operand resolution, per source s:
  - s==0 gives 0.
  - else clr(s) gives wb_data (bypass, because the register file still returns the pre-write value this cycle).
  - else rf_read_data.
- Output register:
  - On accept: out_valid<=1 and capture op1, op2, rd, rd_we.
  - Else if out_ready: out_valid<=0.
  - Else hold all outputs stable.
- stall_count increments each cycle in_valid && hazard; it saturates at 16'hFFFF. A downstream-only stall (out_valid && !out_ready) is not counted.

## Timing
- Reset values: out_valid 0, out_op1 0, out_op2 0, out_rd 0, out_rd_we 0, stall_count 0, all pending bits 0. Reset asserted mid-operation discards the held bundle and all pending bits.
- Latency: accept at edge N, bundle valid after edge N; throughput 1 per cycle when no hazard and out_ready=1.
- A stalled source becomes issuable in the same cycle its writeback is on the wb bus, with the bypassed value.
- A full output register with out_ready=1 accepts a new instruction in the same cycle (no bubble).

## Test plan
- Independent stream: rs1=1, rs2=2, with rf data 0x11/0x22 and out_ready=1 -> one bundle per cycle; out_op1=0x11, out_op2=0x22; stall_count stays 0.
- RAW: issue rd=5 we=1, then rs1=5 -> in_ready=0 for 3 cycles and stall_count=3. Then wb_valid with addr 5 and data 0xDEADBEEF -> accepted that cycle, and out_op1=0xDEADBEEF one cycle later.
- r0 handling: rs1=0 with rf_read_data1=0xFFFF_FFFF -> out_op1=0. Issue rd=0 we=1 -> no pending bit; a following rs1=0 issues without stall.
- Simultaneous set/clear: reg 7 pending; the cycle wb_addr=7 arrives, issue rd=7 we=1 -> accepted; pending[7] remains 1; a later rs1=7 stalls until a second writeback.
- Backpressure: out_ready=0 for 4 cycles with bundle held -> outputs unchanged, in_ready=0, stall_count unchanged. Then out_ready=1 with in_valid -> new bundle loaded on the same edge.
- Reset mid-op: pending[3]=1 and out_valid=1, reset asserted -> all outputs 0; after release, rs1=3 issues without stall. Saturation: force 65540 hazard cycles -> stall_count=0xFFFF.
